// File: rtl/linear_interp.sv
// Two-tap linear interpolator: do_pix = sat(round((pix0*coe0 + pix1*coe1) / unity)).
// Fixed 4-cycle pipeline with no back-pressure; coefficients arrive one cycle after di_en.
module linear_interp #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   di_en,
  input  logic [PIXEL_WIDTH-1:0] di_pix0,
  input  logic [PIXEL_WIDTH-1:0] di_pix1,
  input  logic                   di_sof,
  input  logic                   di_eol,
  input  logic [COE_WIDTH-1:0]   coe0,
  input  logic [COE_WIDTH-1:0]   coe1,
  output logic [PIXEL_WIDTH-1:0] do_pix,
  output logic                   do_en,
  output logic                   do_sof,
  output logic                   do_eol
);

  localparam int PRODW = PIXEL_WIDTH + COE_WIDTH;
  localparam int SUMW  = PRODW + 1;
  localparam logic [SUMW-1:0]        RND    = SUMW'(1) << (COE_WIDTH - 2);
  localparam logic [PIXEL_WIDTH-1:0] MAXPIX = '1;

  // vld_q[k] is the valid bit of stage Sk; vld_q[3] drives do_en
  logic [3:0]             vld_q;

  logic [PIXEL_WIDTH-1:0] pix0_q, pix1_q;
  logic                   sof0_q, eol0_q;

  logic [PRODW-1:0]       prod0_q, prod1_q, prod0_d, prod1_d;
  logic                   sof1_q, eol1_q;

  logic [SUMW-1:0]        sum_q, sum_d;
  logic                   sof2_q, eol2_q;

  logic [SUMW-1:0]        shifted;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                   sof3_q, eol3_q;

  always_comb begin
    prod0_d = PRODW'(pix0_q) * PRODW'(coe0);
    prod1_d = PRODW'(pix1_q) * PRODW'(coe1);
    sum_d   = SUMW'(prod0_q) + SUMW'(prod1_q) + RND;
    shifted = sum_q >> (COE_WIDTH - 1);
    pix_d   = shifted[PIXEL_WIDTH-1:0];
    if (shifted > SUMW'(MAXPIX)) begin
      pix_d = MAXPIX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      pix0_q  <= '0;
      pix1_q  <= '0;
      sof0_q  <= 1'b0;
      eol0_q  <= 1'b0;
      prod0_q <= '0;
      prod1_q <= '0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      sum_q   <= '0;
      sof2_q  <= 1'b0;
      eol2_q  <= 1'b0;
      pix_q   <= '0;
      sof3_q  <= 1'b0;
      eol3_q  <= 1'b0;
    end else begin
      vld_q <= {vld_q[2:0], di_en};
      // Each stage loads only behind a valid sample so idle cycles hold data
      if (di_en) begin
        pix0_q <= di_pix0;
        pix1_q <= di_pix1;
        sof0_q <= di_sof;
        eol0_q <= di_eol;
      end
      if (vld_q[0]) begin
        prod0_q <= prod0_d;
        prod1_q <= prod1_d;
        sof1_q  <= sof0_q;
        eol1_q  <= eol0_q;
      end
      if (vld_q[1]) begin
        sum_q  <= sum_d;
        sof2_q <= sof1_q;
        eol2_q <= eol1_q;
      end
      if (vld_q[2]) begin
        pix_q  <= pix_d;
        sof3_q <= sof2_q;
        eol3_q <= eol2_q;
      end
    end
  end

  // Sideband registers hold their last value; only expose them with the strobe
  assign do_en  = vld_q[3];
  assign do_pix = pix_q;
  assign do_sof = sof3_q & vld_q[3];
  assign do_eol = eol3_q & vld_q[3];

endmodule

// File: tb/tb_linear_interp.sv
// Scoreboard bench for linear_interp: expected results queued at drive time, popped on do_en.
module tb_linear_interp;

  localparam int PW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          di_en;
  logic [PW-1:0] di_pix0, di_pix1;
  logic          di_sof, di_eol;
  logic [CW-1:0] coe0, coe1;
  logic [PW-1:0] do_pix;
  logic          do_en, do_sof, do_eol;

  linear_interp #(.PIXEL_WIDTH(PW), .COE_WIDTH(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .di_en   (di_en),
    .di_pix0 (di_pix0),
    .di_pix1 (di_pix1),
    .di_sof  (di_sof),
    .di_eol  (di_eol),
    .coe0    (coe0),
    .coe1    (coe1),
    .do_pix  (do_pix),
    .do_en   (do_en),
    .do_sof  (do_sof),
    .do_eol  (do_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   pix;
    logic sof;
    logic eol;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic mon_on = 1'b0;

  logic          prev_en = 1'b0;
  logic [CW-1:0] prev_c0 = '0, prev_c1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int model(input int p0, input int p1, input int c0, input int c1);
    int s;
    int r;
    s = p0 * c0 + p1 * c1 + (1 << (CW - 2));
    r = s >> (CW - 1);
    return (r > (1 << PW) - 1) ? (1 << PW) - 1 : r;
  endfunction

  // One cycle of stimulus; coefficients of this sample go out on the next call.
  task automatic drive(input logic en, input int p0, input int p1, input logic sof,
                       input logic eol, input int c0, input int c1, input int exp_pix);
    exp_t e;
    @(posedge clk); #1;
    di_en   = en;
    di_pix0 = PW'(p0);
    di_pix1 = PW'(p1);
    di_sof  = sof;
    di_eol  = eol;
    if (prev_en) begin
      coe0 = prev_c0;
      coe1 = prev_c1;
    end else begin
      coe0 = CW'($urandom);
      coe1 = CW'($urandom);
    end
    if (en) begin
      e.pix = (exp_pix >= 0) ? exp_pix : model(p0, p1, c0, c1);
      e.sof = sof;
      e.eol = eol;
      e.cyc = cyc;
      q.push_back(e);
    end
    prev_en = en;
    prev_c0 = CW'(c0);
    prev_c1 = CW'(c1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                                      1'b1, 1'b1, 0, 0, -1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (do_en) begin
        if (q.size() == 0) begin
          chk("spurious_do_en", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("do_pix", 32'(do_pix), 32'(e.pix));
          chk("do_sof", 32'(do_sof), 32'(e.sof));
          chk("do_eol", 32'(do_eol), 32'(e.eol));
          chk("latency", 32'(cyc - e.cyc), 32'd4);
        end
      end else begin
        chk("sof_idle", 32'(do_sof), 32'd0);
        chk("eol_idle", 32'(do_eol), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; di_en = 1'b0; di_pix0 = '0; di_pix1 = '0;
    di_sof = 1'b0; di_eol = 1'b0; coe0 = '0; coe1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_do_en",  32'(do_en),  32'd0);
    chk("reset_do_pix", 32'(do_pix), 32'd0);
    chk("reset_do_sof", 32'(do_sof), 32'd0);
    chk("reset_do_eol", 32'(do_eol), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // Directed points with hand-computed results
    drive(1'b1, 100, 200, 1'b0, 1'b0, 512, 0,   100);
    drive(1'b1, 100, 201, 1'b0, 1'b0, 256, 256, 151);
    drive(1'b1, 255, 255, 1'b0, 1'b0, 512, 512, 255);
    idle(2);
    drive(1'b1, 0,   0,   1'b1, 1'b0, 1023, 1023, 0);
    idle(1);
    drive(1'b1, 1,   0,   1'b0, 1'b1, 256, 0,   1);
    drive(1'b1, 0,   1,   1'b0, 1'b0, 0,   255, 0);
    idle(6);

    // Full line burst, di_en held high
    for (int i = 0; i < 1920; i++)
      drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), i == 0, i == 1919,
            $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
    idle(6);

    // Mid-stream reset with three samples in flight plus one in the reset cycle
    for (int i = 0; i < 3; i++)
      drive(1'b1, 200, 100, 1'b1, 1'b1, 300, 300, -1);
    @(posedge clk); #1;
    rst = 1'b1; di_en = 1'b1; di_sof = 1'b1; di_eol = 1'b1;
    q.delete();
    prev_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; di_en = 1'b0;
    @(negedge clk);
    chk("rst_do_en",  32'(do_en),  32'd0);
    chk("rst_do_pix", 32'(do_pix), 32'd0);
    chk("rst_do_sof", 32'(do_sof), 32'd0);
    chk("rst_do_eol", 32'(do_eol), 32'd0);
    idle(6);
    drive(1'b1, 100, 200, 1'b1, 1'b0, 512, 0, 100);
    idle(6);

    // Random gaps, pixels and coefficients
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
    idle(8);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
